inst_mem_port: RTL

- Instruction-side memory responder.
- Serves single-word fetch requests from the fetch stage over the instEn/instAddr -> memInstOutEn/memInst protocol.
- Reads the word as four bytes from the byte-wide synchronous RAM, assembles it little-endian and returns it with a one-cycle valid pulse.
- Mirrors every returned word to the icache fill port.
- Aborts in-flight reads on branch mispredict or icache hit.

---
 rtl/inst_mem_port_if.sv | 30 +++
 rtl/inst_mem_port.sv | 123 ++++++++++++
 2 files changed

// File: rtl/inst_mem_port_if.sv
// Bus bundle for the instruction memory port: fetch request/response,
// byte RAM read channel and icache fill channel.
interface inst_mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              instEn;
  logic [ADDR_W-1:0] instAddr;
  logic              hit;
  logic              misTaken;
  logic              memInstOutEn;
  logic [INST_W-1:0] memInst;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_din;
  logic              cacheWrEn;
  logic [ADDR_W-1:0] cacheWrAddr;
  logic [INST_W-1:0] cacheWrInst;

  // Environment side: fetch stage, RAM data return, icache fill sink.
  modport master (
    output instEn, instAddr, hit, misTaken, mem_din,
    input  memInstOutEn, memInst, mem_a, cacheWrEn, cacheWrAddr, cacheWrInst
  );

  // Responder side.
  modport slave (
    input  instEn, instAddr, hit, misTaken, mem_din,
    output memInstOutEn, memInst, mem_a, cacheWrEn, cacheWrAddr, cacheWrInst
  );
endinterface

// File: rtl/inst_mem_port.sv
// Instruction-side memory responder. Reads a 32-bit word as four bytes from
// a byte-wide synchronous RAM (1-cycle read latency), assembles it
// little-endian, returns it with a one-cycle valid and mirrors it to the
// icache fill port. A new request restarts the read; mispredict or icache
// hit abandons it.
module inst_mem_port #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  inst_mem_port_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [23:0]       buf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] last_q;

  logic              final_s;
  logic              cancel_s;
  logic              valid_s;
  logic [INST_W-1:0] word_s;
  logic [ADDR_W-1:0] mem_a_s;

  // Final-cycle detection, cancellation and combinational word assembly.
  always_comb begin
    final_s  = (state_q == READ) && (cnt_q == 3'd4);
    cancel_s = bus.misTaken | bus.hit;
    // The last byte arrives on mem_din in the final cycle itself, so the
    // word is valid only combinationally; rdy=0 and rst force strobes low.
    valid_s  = !rst && rdy && final_s && !cancel_s;
    word_s   = {bus.mem_din, buf_q};
  end

  // RAM byte address: A+cnt while fetching, A+3 held in the final cycle.
  always_comb begin
    mem_a_s = {ADDR_W{1'b0}};
    if (state_q == READ) begin
      if (cnt_q < 3'd4) begin
        mem_a_s = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
      end else begin
        mem_a_s = addr_q + {{(ADDR_W-2){1'b0}}, 2'd3};
      end
    end else begin
      mem_a_s = {ADDR_W{1'b0}};
    end
  end

  // Output drive; memInst keeps the last returned word between pulses.
  always_comb begin
    bus.mem_a        = mem_a_s;
    bus.memInstOutEn = valid_s;
    bus.cacheWrEn    = valid_s;
    if (valid_s) begin
      bus.memInst     = word_s;
      bus.cacheWrAddr = addr_q;
      bus.cacheWrInst = word_s;
    end else begin
      bus.memInst     = last_q;
      bus.cacheWrAddr = {ADDR_W{1'b0}};
      bus.cacheWrInst = {INST_W{1'b0}};
    end
  end

  // Read sequencer: accept beats abort, abort beats advance; rdy=0 freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      buf_q   <= 24'd0;
      addr_q  <= {ADDR_W{1'b0}};
      last_q  <= {INST_W{1'b0}};
    end else if (!rdy) begin
      state_q <= state_q;
      cnt_q   <= cnt_q;
      buf_q   <= buf_q;
      addr_q  <= addr_q;
      last_q  <= last_q;
    end else begin
      if (valid_s) begin
        last_q <= word_s;
      end else begin
        last_q <= last_q;
      end
      if (bus.instEn) begin
        // Restart at the new address; any partial word is dropped.
        state_q <= READ;
        cnt_q   <= 3'd0;
        buf_q   <= 24'd0;
        addr_q  <= bus.instAddr;
      end else if (cancel_s) begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
      end else if (state_q == READ) begin
        if (cnt_q == 3'd4) begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end else begin
          // mem_din now carries the byte addressed in the previous cycle.
          case (cnt_q)
            3'd1:    buf_q[7:0]   <= bus.mem_din;
            3'd2:    buf_q[15:8]  <= bus.mem_din;
            3'd3:    buf_q[23:16] <= bus.mem_din;
            default: buf_q        <= buf_q;
          endcase
          cnt_q <= cnt_q + 3'd1;
        end
      end else begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
      end
    end
  end

endmodule
